// File: rtl/fifo_pkg.sv
// Shared constants and types for the sync FIFO and its byte packer.
// Packer FSM state lives here so benches and tools can decode it.
package fifo_pkg;

  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);

  typedef enum logic {
    FILL    = 1'b0,
    PRESENT = 1'b1
  } pack_state_e;

endpackage

// File: rtl/fifo_byte_packer_if.sv
// Packer-facing bundle: FIFO read port, flush level and output word.
// master = packer side, slave = FIFO/downstream side.
interface fifo_byte_packer_if
  import fifo_pkg::*;
#(
  parameter int BPW = 4,
  parameter int DW  = DATA_W
) ();

  localparam int WORD_W = DW * BPW;
  localparam int CNT_W  = $clog2(BPW + 1);

  logic              fifo_empty;
  logic [DW-1:0]     fifo_data;
  logic              fifo_rd_en;
  logic              flush;
  logic [WORD_W-1:0] out_data;
  logic [CNT_W-1:0]  out_bytes;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en,
    input  flush,
    output out_data,
    output out_bytes,
    output out_valid,
    input  out_ready
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en,
    output flush,
    input  out_data,
    input  out_bytes,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fifo_sync.sv
// 16x8 synchronous FIFO; data_out is registered, valid the cycle
// after an accepted read. Writes while full are dropped.
module fifo_sync
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [DATA_W-1:0] data_in,
  input  logic              read_en,
  output logic [DATA_W-1:0] data_out,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              wr_ok;
  logic              rd_ok;

  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign wr_ok = write_en && !full;
  assign rd_ok = read_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      dout_d   = mem_q[rd_ptr_q];
    end
    unique case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  assign data_out = dout_q;

endmodule

// File: rtl/fifo_byte_packer.sv
// Drains bytes from fifo_sync and packs them LSB-first into words,
// with a level flush that emits a partial word once the FIFO is dry.
module fifo_byte_packer
  import fifo_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int WORD_W         = DATA_W * BYTES_PER_WORD
) (
  input  logic              clk,
  input  logic              reset,
  fifo_byte_packer_if.master bus
);

  localparam int BPW   = BYTES_PER_WORD;
  localparam int CNT_W = $clog2(BPW + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BPW);
  localparam logic [CNT_W:0]   SUM_FULL = (CNT_W+1)'(BPW);

  pack_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  bytes_q, bytes_d;
  logic [CNT_W:0]    pending;
  logic              rd_en;
  logic              valid;
  logic              flush_now;

  // Reads already issued count toward the word so we never over-fetch.
  assign pending = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inflight_q};

  assign flush_now = bus.flush && (cnt_q != '0)
                  && !inflight_q && bus.fifo_empty;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    inflight_d = 1'b0;
    data_d     = data_q;
    bytes_d    = bytes_q;
    rd_en      = 1'b0;
    valid      = 1'b0;
    unique case (state_q)
      FILL: begin
        rd_en      = !bus.fifo_empty && (pending < SUM_FULL);
        inflight_d = rd_en;
        if (inflight_q) begin
          for (int i = 0; i < BPW; i++) begin
            if (cnt_q == CNT_W'(i))
              data_d[i*DATA_W +: DATA_W] = bus.fifo_data;
          end
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_FULL) begin
          state_d = PRESENT;
          bytes_d = CNT_FULL;
        end else if (flush_now) begin
          state_d = PRESENT;
          bytes_d = cnt_q;
        end
      end
      PRESENT: begin
        valid = 1'b1;
        if (bus.out_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          data_d  = '0;
          bytes_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= FILL;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      data_q     <= '0;
      bytes_q    <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      data_q     <= data_d;
      bytes_q    <= bytes_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.out_valid  = valid;
  assign bus.out_data   = data_q;
  assign bus.out_bytes  = bytes_q;

endmodule

// File: tb/tb_fifo_byte_packer.sv
// Bench: fifo_sync feeding fifo_byte_packer, BPW=4, checked
// against a byte-stream scoreboard.
module tb_fifo_byte_packer;

  typedef struct packed {
    logic [2:0]  n;
    logic [31:0] d;
  } word_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       full;

  int n_cmp = 0;
  int n_err = 0;
  int viol = 0;
  bit done = 1'b0;

  logic [7:0] sb[$];
  word_t      got[$];

  fifo_byte_packer_if #(.BPW(4)) bus ();

  fifo_sync u_fifo (
    .clk      (clk),
    .reset    (reset),
    .write_en (wr_en),
    .data_in  (din),
    .read_en  (bus.fifo_rd_en),
    .data_out (bus.fifo_data),
    .full     (full),
    .empty    (bus.fifo_empty)
  );

  fifo_byte_packer #(.BYTES_PER_WORD(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic [31:0] pd = '0;
  logic [2:0]  pb = '0;

  always @(negedge clk) begin
    if (reset) begin
      pv = 1'b0;
    end else begin
      if (bus.fifo_rd_en && bus.fifo_empty) viol++;
      if (pv && !pr) begin
        if (!bus.out_valid) viol++;
        else if (bus.out_data !== pd || bus.out_bytes !== pb) viol++;
      end
      if (bus.out_valid && bus.out_ready)
        got.push_back('{n: bus.out_bytes, d: bus.out_data});
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = bus.out_data;
      pb = bus.out_bytes;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [7:0] b);
    int t;
    t = 0;
    while (full && t < 500) begin
      cyc(1);
      t++;
    end
    if (full) begin
      chk("wr_tmo", full, 0);
      return;
    end
    wr_en = 1'b1;
    din   = b;
    sb.push_back(b);
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic expect_word(input int exp_n, input string tag);
    word_t w;
    logic [31:0] e;
    int t;
    t = 0;
    while (got.size() == 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_tmo"}, got.size() != 0, 1);
    if (got.size() == 0) return;
    w = got.pop_front();
    e = '0;
    for (int i = 0; i < exp_n; i++)
      if (sb.size() > 0) e[i*8 +: 8] = sb.pop_front();
    chk({tag, "_data"}, w.d, e);
    chk({tag, "_bytes"}, w.n, exp_n);
  endtask

  initial begin
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    cyc(3);
    reset = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_valid", bus.out_valid, 0);
      chk("rst_rden", bus.fifo_rd_en, 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_bytes", bus.out_bytes, 0);
    end
    cyc(1);

    // 2: two full words
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) wr(8'(i));
    expect_word(4, "w1");
    expect_word(4, "w2");

    // 3: stall, fill FIFO, overflow attempt
    bus.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) wr(8'(i));
    cyc(10);
    @(negedge clk);
    chk("stall_valid", bus.out_valid, 1);
    chk("stall_data", bus.out_data, 32'h04030201);
    chk("stall_nohs", got.size(), 0);
    cyc(1);
    for (int i = 0; i < 16; i++) wr(8'(8'h20 + i));
    cyc(2);
    chk("fifo_full", full, 1);
    wr_en = 1'b1;
    din   = 8'hEE;
    cyc(1);
    wr_en = 1'b0;
    chk("stall_data2", bus.out_data, 32'h04030201);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) expect_word(4, "fullq");
    cyc(10);
    chk("no_overflow", got.size(), 0);

    // 4: flush partial word, then flush with nothing held
    wr(8'hAA);
    wr(8'hBB);
    wr(8'hCC);
    cyc(6);
    chk("no_flush_word", got.size(), 0);
    bus.flush = 1'b1;
    expect_word(3, "flush3");
    cyc(10);
    chk("flush_empty", got.size(), 0);
    chk("flush_valid", bus.out_valid, 0);
    bus.flush = 1'b0;

    // 5: reset mid-word
    wr(8'h55);
    wr(8'h66);
    cyc(4);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    cyc(1);
    for (int i = 0; i < 4; i++) wr(8'(8'h11 + i));
    expect_word(4, "post_rst");
    chk("post_rst_val", sb.size(), 0);

    // 6: random traffic with stalls
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          cyc($urandom_range(0, 2));
          wr(8'($urandom_range(0, 255)));
        end
        done = 1'b1;
      end
      begin
        int g;
        g = 0;
        while ((!done || got.size() < 50) && g < 6000) begin
          bus.out_ready = ($urandom_range(0, 3) != 0);
          cyc(1);
          g++;
        end
      end
    join
    bus.out_ready = 1'b1;
    cyc(2);
    chk("rnd_count", got.size(), 50);
    for (int i = 0; i < 50; i++) expect_word(4, "rnd");
    chk("sb_drained", sb.size(), 0);
    chk("invariants", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
